// File: rtl/counter_capture.sv
// Captures {overflow-event count, live counter} snapshots into a small FIFO.
// A saturating event counter tags each entry; the head is presented with valid/ready.
module counter_capture #(
  parameter int DEPTH = 4,
  parameter int OVW   = 8
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic [7:0]                counter,
  input  logic                      OV,
  input  logic                      CAP,
  input  logic                      CLR_OVC,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [OVW+7:0]            rd_data,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      full,
  output logic                      dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OVW + 8;

  function automatic logic [OVW-1:0] sat_inc(input logic [OVW-1:0] v);
    return (&v) ? v : v + OVW'(1);
  endfunction

  logic [OVW-1:0] ovc;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_ptr_nxt;
  logic [CW-1:0]  count_nxt;
  logic [EW-1:0]  entry_p0;
  logic [EW-1:0]  head_nxt;
  logic           push;
  logic           pop;

  assign full     = (fifo_count == CW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign push     = CAP && (!full || pop);
  assign entry_p0 = {ovc, counter};

  // Next head: a push into the slot the read pointer lands on bypasses memory.
  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = fifo_count;
    if (push && !pop)
      count_nxt = fifo_count + CW'(1);
    else if (pop && !push)
      count_nxt = fifo_count - CW'(1);
    head_nxt = '0;
    if (count_nxt != '0)
      head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? entry_p0 : mem[rd_ptr_nxt];
  end

  // Stage p0 -> registered state
  always_ff @(posedge clk) begin
    if (!Reset) begin
      ovc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      dropped    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (CLR_OVC)
        ovc <= '0;
      else if (OV)
        ovc <= sat_inc(ovc);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      if (CAP && !push)
        dropped <= 1'b1;
      rd_valid <= (count_nxt != '0);
      rd_data  <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry_p0;
  end

endmodule
